// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider, unsigned or two's-complement signed, one quotient bit per cycle.
// Latency N+1 cycles from start acceptance to done (1 cycle on divide-by-zero); start ignored while busy.
module restoring_divider_seq #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sgn,
    input  logic [N-1:0] x,
    input  logic [M-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [M-1:0] r,
    output logic         dbz,
    output logic         ovf
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  a_q;
    logic [M-1:0]  b_q;
    logic [M-1:0]  p_q;
    logic          xs_q, ys_q;
    logic          dbz_pend_q, ovf_pend_q;
    logic          busy_q, done_q, dbz_q, ovf_q;
    logic [N-1:0]  q_q;
    logic [M-1:0]  r_q;

    logic          x_neg, y_neg;
    logic [N-1:0]  x_mag;
    logic [M-1:0]  y_mag;
    logic [M:0]    rem_sh;
    logic [M+1:0]  trial;
    logic          q_bit;
    logic [M-1:0]  p_step;
    logic [N-1:0]  a_step;
    logic [N-1:0]  q_fix;
    logic [M-1:0]  r_fix;

    always_comb begin
        x_neg  = sgn & x[N-1];
        y_neg  = sgn & y[M-1];
        x_mag  = x_neg ? -x : x;
        y_mag  = y_neg ? -y : y;
        // Top bit of the trial difference is the borrow: set means the divisor did not fit.
        rem_sh = {p_q, a_q[N-1]};
        trial  = {1'b0, rem_sh} - {2'b00, b_q};
        q_bit  = ~trial[M+1];
        p_step = q_bit ? trial[M-1:0] : rem_sh[M-1:0];
        a_step = {a_q[N-2:0], q_bit};
        q_fix  = (xs_q ^ ys_q) ? -a_q : a_q;
        r_fix  = xs_q ? -p_q : p_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            xs_q       <= 1'b0;
            ys_q       <= 1'b0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        xs_q       <= x_neg;
                        ys_q       <= y_neg;
                        b_q        <= y_mag;
                        p_q        <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        ovf_pend_q <= sgn && (x == {1'b1, {(N-1){1'b0}}}) && (y == '1);
                        if (y == '0) begin
                            // Raw dividend is kept so its low bits can be reported as the remainder.
                            dbz_pend_q <= 1'b1;
                            a_q        <= x;
                            state_q    <= FIX;
                        end else begin
                            dbz_pend_q <= 1'b0;
                            a_q        <= x_mag;
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    a_q   <= a_step;
                    p_q   <= p_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N-1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (dbz_pend_q) begin
                        q_q   <= '1;
                        r_q   <= a_q[M-1:0];
                        dbz_q <= 1'b1;
                        ovf_q <= 1'b0;
                    end else begin
                        q_q   <= q_fix;
                        r_q   <= r_fix;
                        dbz_q <= 1'b0;
                        ovf_q <= ovf_pend_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dbz  = dbz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Bench for restoring_divider_seq: directed vectors plus randomized operands against an arithmetic model.
module tb_restoring_divider_seq;

    localparam int N = 8;
    localparam int M = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sgn;
    logic [N-1:0] x;
    logic [M-1:0] y;
    logic         busy, done, dbz, ovf;
    logic [N-1:0] q;
    logic [M-1:0] r;

    int compares = 0;
    int fails    = 0;

    restoring_divider_seq #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, which truncates toward zero with the remainder taking the dividend's sign.
    function automatic void model(input logic s, input logic [N-1:0] xv, input logic [M-1:0] yv,
                                  output logic [N-1:0] eq, output logic [M-1:0] er,
                                  output logic ed, output logic eo);
        longint xi, yi, qi, ri;
        if (yv == '0) begin
            eq = '1;
            er = xv[M-1:0];
            ed = 1'b1;
            eo = 1'b0;
            return;
        end
        if (s) begin
            xi = longint'($signed(xv));
            yi = longint'($signed(yv));
        end else begin
            xi = longint'(xv);
            yi = longint'(yv);
        end
        qi = xi / yi;
        ri = xi % yi;
        eq = qi[N-1:0];
        er = ri[M-1:0];
        ed = 1'b0;
        eo = s && (xi == -(longint'(1) << (N-1))) && (yi == -1);
    endfunction

    task automatic do_div(input logic s, input logic [N-1:0] xv, input logic [M-1:0] yv,
                          input bit early, input bit poke);
        logic [N-1:0]   eq;
        logic [M-1:0]   er;
        logic           ed, eo;
        logic [N+M+1:0] snap;
        int             lat, n;
        model(s, xv, yv, eq, er, ed, eo);
        lat = (yv == '0) ? 1 : N + 1;
        @(negedge clk);
        start = 1'b1;
        sgn   = s;
        x     = xv;
        y     = yv;
        @(posedge clk);
        #1;
        check("busy_after_accept", 32'(busy), 1);
        check("done_low_after_accept", 32'(done), 0);
        snap  = {q, r, dbz, ovf};
        start = 1'b0;
        sgn   = 1'($urandom);
        x     = N'($urandom);
        y     = M'($urandom);
        n     = 0;
        while (!done && n < 3 * N) begin
            @(posedge clk);
            #1;
            n++;
            if (!done) check("outputs_held", 32'({q, r, dbz, ovf}), 32'(snap));
            if (poke) begin
                start = (n >= 1 && n <= 4);
                x     = 8'd15;
                y     = 4'd1;
                sgn   = 1'b0;
            end
            if (early && n == lat - 1) start = 1'b1;
        end
        check("latency", n, lat);
        check("q", 32'(q), 32'(eq));
        check("r", 32'(r), 32'(er));
        check("dbz", 32'(dbz), 32'(ed));
        check("ovf", 32'(ovf), 32'(eo));
        check("busy_at_done", 32'(busy), 0);
    endtask

    initial begin
        int seen;
        logic s_r;
        logic [N-1:0] x_r;
        logic [M-1:0] y_r;

        rst   = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        x     = '0;
        y     = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", 32'(q), 0);
        check("rst_r", 32'(r), 0);
        check("rst_dbz", 32'(dbz), 0);
        check("rst_ovf", 32'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;

        do_div(1'b0, 8'd9, 4'd2, 1'b0, 1'b0);
        check("u9_2_q", 32'(q), 4);
        check("u9_2_r", 32'(r), 1);

        // Second start raised before the first done edge; it must wait for IDLE.
        do_div(1'b0, 8'd20, 4'd3, 1'b1, 1'b0);
        check("u20_3_q", 32'(q), 6);
        check("u20_3_r", 32'(r), 2);
        do_div(1'b0, 8'd12, 4'd3, 1'b0, 1'b0);
        check("u12_3_q", 32'(q), 4);
        check("u12_3_r", 32'(r), 0);

        do_div(1'b1, 8'hF9, 4'h2, 1'b0, 1'b0);
        check("sm7_2_q", 32'(q), 32'h0FD);
        check("sm7_2_r", 32'(r), 32'h0F);
        do_div(1'b1, 8'h07, 4'hE, 1'b0, 1'b0);
        check("s7_m2_q", 32'(q), 32'h0FD);
        check("s7_m2_r", 32'(r), 1);

        do_div(1'b0, 8'd13, 4'd0, 1'b0, 1'b0);
        check("dbz_q", 32'(q), 32'h0FF);
        check("dbz_r", 32'(r), 32'h0D);
        check("dbz_flag", 32'(dbz), 1);

        do_div(1'b1, 8'h80, 4'hF, 1'b0, 1'b0);
        check("ovf_flag", 32'(ovf), 1);
        check("ovf_q", 32'(q), 32'h080);
        check("ovf_r", 32'(r), 0);

        do_div(1'b1, 8'hB5, 4'h0, 1'b0, 1'b0);
        do_div(1'b0, 8'd200, 4'd7, 1'b0, 1'b0);

        // Abort 9/2 with reset asserted across the fourth calculation edge.
        @(negedge clk);
        start = 1'b1;
        sgn   = 1'b0;
        x     = 8'd9;
        y     = 4'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_q", 32'(q), 0);
        check("abort_r", 32'(r), 0);
        check("abort_dbz", 32'(dbz), 0);
        check("abort_ovf", 32'(ovf), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);

        // Start held during reset must not launch a division.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        x     = 8'd5;
        y     = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_busy", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;

        do_div(1'b0, 8'd10, 4'd2, 1'b0, 1'b1);
        check("u10_2_q", 32'(q), 5);
        check("u10_2_r", 32'(r), 0);

        for (int i = 0; i < 80; i++) begin
            s_r = 1'($urandom);
            x_r = N'($urandom);
            y_r = M'($urandom);
            do_div(s_r, x_r, y_r, (y_r != '0) && ((i % 5) == 0), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
